// File: rtl/ravan_enc_scheduler.sv
// ravan_enc_scheduler: round-robin two-port sequencer for the RAVAN 64-bit encryption core.
// Optional statistics outputs (blk_count, key_count) when RAVAN_SCHED_STATS_EN is defined.
module ravan_enc_scheduler #(
    parameter int CORE_LAT = 2,
    parameter int TAG_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [63:0]      a_data,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [63:0]      b_data,
    input  logic [TAG_W-1:0] b_tag,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [511:0]     key_in,
    output logic             core_rst,
    output logic [63:0]      core_din,
    output logic [511:0]     core_key,
    input  logic [63:0]      core_dout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_data,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
`ifdef RAVAN_SCHED_STATS_EN
    output logic [31:0]      blk_count,
    output logic [7:0]       key_count,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, KRST, RUN, RESP} state_t;

    state_t           r_state, w_next;
    logic             r_last, r_core_rst, r_id;
    logic [3:0]       r_cnt;
    logic [63:0]      r_din, r_rsp_data;
    logic [511:0]     r_key;
    logic [TAG_W-1:0] r_tag;
    logic             w_idle, w_grant_a, w_grant_b, w_acc_a, w_acc_b, w_acc, w_key_acc, w_done;

    // core_rst is still high on the first cycle out of reset, which keeps all readies low until then
    assign w_idle    = (r_state == IDLE) && !r_core_rst;
    assign w_grant_a = a_valid && (!b_valid || r_last);
    assign w_grant_b = b_valid && !w_grant_a;
    assign a_ready   = w_idle && !key_valid && w_grant_a;
    assign b_ready   = w_idle && !key_valid && w_grant_b;
    assign key_ready = w_idle;
    assign w_acc_a   = a_valid && a_ready;
    assign w_acc_b   = b_valid && b_ready;
    assign w_acc     = w_acc_a || w_acc_b;
    assign w_key_acc = key_valid && key_ready;
    assign w_done    = (r_state == RUN) && (r_cnt == 4'(CORE_LAT - 1));

    assign core_rst  = r_core_rst;
    assign core_din  = r_din;
    assign core_key  = r_key;
    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_id;
    assign rsp_tag   = r_tag;
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_acc ? KRST : IDLE;
            KRST:    w_next = RUN;
            RUN:     w_next = w_done ? RESP : RUN;
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_rst <= 1'b1;
            r_last     <= 1'b1;
            r_cnt      <= 4'd0;
            r_din      <= 64'd0;
            r_key      <= 512'd0;
            r_rsp_data <= 64'd0;
            r_id       <= 1'b0;
            r_tag      <= '0;
        end else begin
            r_core_rst <= (w_next == KRST);
            if (w_key_acc)
                r_key <= key_in;
            if (w_acc) begin
                r_din  <= w_acc_b ? b_data : a_data;
                r_tag  <= w_acc_b ? b_tag : a_tag;
                r_id   <= w_acc_b;
                r_last <= w_acc_b;
            end
            if (w_next == KRST)
                r_cnt <= 4'd0;
            else if (r_state == RUN)
                r_cnt <= r_cnt + 4'd1;
            if (w_done)
                r_rsp_data <= core_dout;
        end
    end

`ifdef RAVAN_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count <= 32'd0;
            key_count <= 8'd0;
        end else begin
            if (rsp_valid && rsp_ready)
                blk_count <= blk_count + 32'd1;
            if (w_key_acc && key_count != 8'hFF)
                key_count <= key_count + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ravan_enc_scheduler.sv
// tb_ravan_enc_scheduler: directed bench for ravan_enc_scheduler with a small counting-mask core model.
module tb_ravan_enc_scheduler;
    localparam logic [511:0] K1 = {8{64'h1000_0000_0000_0001}};
    localparam logic [511:0] K2 = {8{64'hDEAD_BEEF_CAFE_F00D}};
    localparam logic [511:0] K3 = {8{64'h0F0F_0000_FFFF_1234}};
    localparam logic [63:0]  P1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0]  PA = 64'hAAAA_0000_5555_0001;
    localparam logic [63:0]  PB = 64'hBBBB_1111_2222_0002;
    localparam logic [63:0]  P3 = 64'h3333_4444_5555_6666;
    localparam logic [63:0]  P4 = 64'h4040_4040_ABCD_0004;
    localparam logic [63:0]  P5 = 64'h5555_5555_5555_5555;

    logic         clk = 1'b0, rst_n;
    logic         a_valid, a_ready, b_valid, b_ready, key_valid, key_ready;
    logic [63:0]  a_data, b_data, core_din, core_dout, rsp_data;
    logic [3:0]   a_tag, b_tag, rsp_tag;
    logic [511:0] key_in, core_key;
    logic         core_rst, rsp_valid, rsp_ready, rsp_id, busy;
    logic [3:0]   m_step;
`ifdef RAVAN_SCHED_STATS_EN
    logic [31:0]  blk_count;
    logic [7:0]   key_count;
`endif
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    // Core model: mask counts clocks since the last core_rst, so mistimed capture changes the result
    always @(posedge clk) m_step <= core_rst ? 4'd0 : m_step + 4'd1;
    assign core_dout = core_din ^ core_key[63:0] ^ {16{m_step}};

    ravan_enc_scheduler #(.CORE_LAT(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_tag(a_tag),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_tag(b_tag),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .core_rst(core_rst), .core_din(core_din), .core_key(core_key), .core_dout(core_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag),
`ifdef RAVAN_SCHED_STATS_EN
        .blk_count(blk_count), .key_count(key_count),
`endif
        .busy(busy)
    );

    // With CORE_LAT=2 the model has counted exactly one clock past reset when the result is captured
    function automatic logic [63:0] exp_ct(input logic [63:0] p, input logic [511:0] k);
        return p ^ k[63:0] ^ 64'h1111_1111_1111_1111;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic load_key(input logic [511:0] k);
        key_valid = 1'b1;
        key_in = k;
        #1;
        checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL key_ready: got %b want 1", key_ready); end
        tick();
        key_valid = 1'b0;
        checks++; if (core_key !== k) begin errors++; $display("FAIL core_key_load: got %h want %h", core_key[63:0], k[63:0]); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_valid = 1'b1;
        repeat (2) tick();
        checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL rst_core_rst: got %b want 1", core_rst); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (a_ready !== 1'b0 || key_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got a=%b k=%b want 0", a_ready, key_ready); end
        checks++; if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_tag !== 4'd0) begin errors++; $display("FAIL rst_rsp: got v=%b id=%b tag=%h want 0", rsp_valid, rsp_id, rsp_tag); end
        checks++; if (core_din !== 64'd0 || core_key !== 512'd0 || rsp_data !== 64'd0) begin errors++; $display("FAIL rst_regs: got din=%h key=%h data=%h want 0", core_din, core_key[63:0], rsp_data); end
        a_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (core_rst !== 1'b0) begin errors++; $display("FAIL post_rst_core_rst: got %b want 0", core_rst); end
        checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL post_rst_idle: got kr=%b busy=%b want 1/0", key_ready, busy); end
    endtask

    task automatic test_single;
        load_key(K1);
        rsp_ready = 1'b1;
        a_valid = 1'b1; a_data = P1; a_tag = 4'd3;
        #1;
        checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL single_grant: got a=%b b=%b want 1/0", a_ready, b_ready); end
        tick();
        a_valid = 1'b0;
        checks++; if (core_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_krst: got rst=%b busy=%b want 1/1", core_rst, busy); end
        checks++; if (core_din !== P1) begin errors++; $display("FAIL single_din: got %h want %h", core_din, P1); end
        tick();
        checks++; if (core_rst !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_run1: got rst=%b v=%b want 0/0", core_rst, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || core_din !== P1) begin errors++; $display("FAIL single_run2: got v=%b din=%h want 0/%h", rsp_valid, core_din, P1); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== exp_ct(P1, K1)) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, exp_ct(P1, K1)); end
        checks++; if (rsp_id !== 1'b0 || rsp_tag !== 4'd3) begin errors++; $display("FAIL single_rsp_idtag: got id=%b tag=%h want 0/3", rsp_id, rsp_tag); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_done: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin;
        int n = 0, last_c = 0;
        do_reset();
        load_key(K2);
        rsp_ready = 1'b1;
        a_valid = 1'b1; a_data = PA; a_tag = 4'd1;
        b_valid = 1'b1; b_data = PB; b_tag = 4'd2;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                checks++; if (rsp_id !== n[0]) begin errors++; $display("FAIL rr_id%0d: got %b want %b", n, rsp_id, n[0]); end
                checks++; if (rsp_tag !== (n[0] ? 4'd2 : 4'd1)) begin errors++; $display("FAIL rr_tag%0d: got %h want %h", n, rsp_tag, n[0] ? 4'd2 : 4'd1); end
                checks++; if (rsp_data !== exp_ct(n[0] ? PB : PA, K2)) begin errors++; $display("FAIL rr_data%0d: got %h want %h", n, rsp_data, exp_ct(n[0] ? PB : PA, K2)); end
                if (n > 0) begin
                    checks++; if (c - last_c != 5) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 5", n, c - last_c); end
                end
                last_c = c;
                n++;
            end
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", n); end
        tick();
    endtask

    task automatic test_key_priority;
        key_valid = 1'b1; key_in = K3;
        a_valid = 1'b1; a_data = P3; a_tag = 4'd5;
        #1;
        checks++; if (key_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL kp_first: got kr=%b ar=%b want 1/0", key_ready, a_ready); end
        tick();
        key_valid = 1'b0;
        #1;
        checks++; if (core_key !== K3 || a_ready !== 1'b1) begin errors++; $display("FAIL kp_second: got key=%h ar=%b want %h/1", core_key[63:0], a_ready, K3[63:0]); end
        tick();
        a_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL kp_busy: got %b want 1", busy); end
        for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL kp_timeout: got v=%b want 1", rsp_valid); end
        checks++; if (rsp_data !== exp_ct(P3, K3) || rsp_id !== 1'b0 || rsp_tag !== 4'd5) begin errors++; $display("FAIL kp_rsp: got %h id=%b tag=%h want %h/0/5", rsp_data, rsp_id, rsp_tag, exp_ct(P3, K3)); end
        tick();
    endtask

    task automatic test_backpressure;
        rsp_ready = 1'b0;
        b_valid = 1'b1; b_data = P4; b_tag = 4'd7;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL bp_grant: got %b want 1", b_ready); end
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 10 && rsp_valid !== 1'b1; c++) tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout: got v=%b want 1", rsp_valid); end
        a_valid = 1'b1; a_data = P5; key_valid = 1'b1; key_in = K1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_ct(P4, K3) || rsp_id !== 1'b1 || rsp_tag !== 4'd7) begin errors++; $display("FAIL bp_hold%0d: got v=%b %h id=%b tag=%h", c, rsp_valid, rsp_data, rsp_id, rsp_tag); end
            checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || key_ready !== 1'b0 || core_key !== K3) begin errors++; $display("FAIL bp_ready%0d: got a=%b b=%b k=%b want 0", c, a_ready, b_ready, key_ready); end
        end
        a_valid = 1'b0; key_valid = 1'b0; rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_mid_reset;
        logic seen = 1'b0;
        rsp_ready = 1'b1;
        a_valid = 1'b1; a_data = P5; a_tag = 4'd9;
        tick();
        a_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_ctrl: got rst=%b busy=%b v=%b want 1/0/0", core_rst, busy, rsp_valid); end
        checks++; if (core_key !== 512'd0 || core_din !== 64'd0 || rsp_tag !== 4'd0 || rsp_id !== 1'b0) begin errors++; $display("FAIL mr_regs: got key=%h din=%h tag=%h id=%b want 0", core_key[63:0], core_din, rsp_tag, rsp_id); end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mr_no_rsp: got response=%b want 0", seen); end
    endtask

`ifdef RAVAN_SCHED_STATS_EN
    task automatic test_stats;
        int n = 0;
        do_reset();
        load_key(K1); load_key(K2); load_key(K3);
        rsp_ready = 1'b1;
        a_valid = 1'b1; a_data = P1; a_tag = 4'd1;
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            if (rsp_valid === 1'b1) n++;
        end
        a_valid = 1'b0;
        tick();
        checks++; if (key_count !== 8'd3) begin errors++; $display("FAIL stats_key: got %0d want 3", key_count); end
        checks++; if (blk_count !== 32'd5) begin errors++; $display("FAIL stats_blk: got %0d want 5", blk_count); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        a_valid = 1'b0; a_data = '0; a_tag = '0;
        b_valid = 1'b0; b_data = '0; b_tag = '0;
        key_valid = 1'b0; key_in = '0; rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_key_priority();
        test_backpressure();
        test_mid_reset();
`ifdef RAVAN_SCHED_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/ravan_enc_scheduler.md
# ravan_enc_scheduler

Sequencer and two-port arbiter for the RAVAN 64-bit encryption core. Accepts plaintext blocks from two requesters (A, B) through valid/ready handshakes and grants them round-robin. For each block it pulses the core's synchronous reset so the mask LFSR restarts from its seed. It then holds the block on the core input for a fixed number of cycles, captures the ciphertext, and returns it with requester ID and tag. It also owns the 512-bit key register that drives the core key input, so keys only change between blocks.

## Interface
- `CORE_LAT`, default 2: core clocks from reset release to sampling `core_dout`. Legal range 1..15.
- `TAG_W`, default 4: width of the requester tag carried through to the response.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `a_valid`, in, 1 / `a_ready`, out, 1: requester A handshake.
- `a_data`, in, 64 / `a_tag`, in, TAG_W: requester A plaintext and tag.
- `b_valid`, in, 1 / `b_ready`, out, 1: requester B handshake.
- `b_data`, in, 64 / `b_tag`, in, TAG_W: requester B plaintext and tag.
- `key_valid`, in, 1 / `key_ready`, out, 1: key load handshake.
- `key_in`, in, 512: new key.
- `core_rst`, out, 1: synchronous active-high reset to the core.
- `core_din`, out, 64: registered plaintext to the core.
- `core_key`, out, 512: registered key to the core.
- `core_dout`, in, 64: core ciphertext.
- `rsp_valid`, out, 1 / `rsp_ready`, in, 1: response handshake.
- `rsp_data`, out, 64: ciphertext.
- `rsp_id`, out, 1: 0 = A, 1 = B.
- `rsp_tag`, out, TAG_W: tag captured at acceptance.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → KRST → RUN → RESP → IDLE.
- IDLE:
  - `key_ready`=1.
  - `a_ready`/`b_ready` are 1 only when `key_valid`=0. A pending key load has priority over data, and both are never accepted in the same cycle.
  - Key accept: register `key_in` into `core_key`. Stay in IDLE.
  - Arbitration: round-robin with pointer `last`, reset value 1, so A wins first.
    - Only one valid: that requester is granted.
    - Both valid: the requester that is not `last` is granted.
    - Only the granted ready is asserted; the other is 0.
  - Data accept: latch data into `core_din`, latch tag and id, set `last`=id, go to KRST.
- KRST: `core_rst`=1 for exactly one cycle, then go to RUN with counter=0.
- RUN:
  - `core_rst`=0 and `core_din` held stable.
  - Counter increments each cycle.
  - When counter==CORE_LAT-1, capture `core_dout` into `rsp_data` and go to RESP.
- RESP: `rsp_valid`=1. Data, id and tag are held stable until `rsp_ready`=1, then go to IDLE.
- All ready outputs are 0 outside IDLE. No requests are queued.
- Counter is 4 bits wide and never wraps: it is cleared on KRST entry.

## Timing
- Reset values (asserted asynchronously): state=IDLE, `core_rst`=1, `core_din`=0, `core_key`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `rsp_tag`=0, `last`=1, `busy`=0, all ready outputs=0. Counter=0.
- First cycle after `rst_n` deasserts: `core_rst` drops to 0 and all outputs take their IDLE values.
- Latency from an accept edge at cycle T:
  - `core_rst`=1 during cycle T+1.
  - `rsp_valid` rises at T+2+CORE_LAT.
  - With `rsp_ready` held high, the next accept is possible at T+3+CORE_LAT.
- Back-to-back throughput: one block per CORE_LAT+3 cycles.
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `rsp_valid` with `rsp_ready`=0 holds indefinitely.
- Requester deasserting valid without a handshake: legal; nothing is latched.
- `rst_n` asserted mid-block: the block is dropped and no response is produced. `core_key` returns to 0, so software reloads the key.

## Configuration
- `RAVAN_SCHED_STATS_EN` defined:
  - Adds output `blk_count` [31:0]: increments on every response handshake (`rsp_valid`&`rsp_ready`), wraps 0xFFFFFFFF→0, reset 0.
  - Adds output `key_count` [7:0]: increments on every key accept, saturates at 0xFF, reset 0.
- Not defined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, load key K=512'h1…, then A sends 0x0123_4567_89AB_CDEF with tag 3 → `core_rst` high exactly 1 cycle; `rsp_valid` at T+4 (CORE_LAT=2); `rsp_data` equals the core model output for K; `rsp_id`=0, `rsp_tag`=3.
- A and B valid continuously with tags 1 and 2, `rsp_ready`=1 → grants alternate A,B,A,B; responses every 5 cycles; ids 0,1,0,1.
- `key_valid` and `a_valid` asserted in the same IDLE cycle → key accepted first and `a_ready`=0; A accepted the next cycle and encrypted under the new key.
- `rsp_ready` held 0 for 10 cycles → `rsp_valid`, data, id and tag stable; `a_ready`=`b_ready`=`key_ready`=0 throughout.
- `rst_n` pulsed low during RUN → outputs take reset values immediately; no response is issued afterwards.
- With `RAVAN_SCHED_STATS_EN` defined: 3 key loads and 5 blocks → `key_count`=3, `blk_count`=5.
